// File: rtl/operand_stage_if.sv
// rtl/operand_stage_if.sv - controller/ALU-facing signal bundle for the operand stage
interface operand_stage_if #(
  parameter int W = 16
);
  // controller side: register file and operand registers
  logic [W-1:0] data_in;
  logic         vsel;
  logic [2:0]   writenum;
  logic         write;
  logic [2:0]   readnum;
  logic         loada;
  logic         loadb;
  logic [1:0]   shift;
  logic         asel;
  logic         bsel;
  logic [W-1:0] sximm5;
  logic         loadc;
  logic         loads;

  // ALU side
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic [W-1:0] alu_out;
  logic [2:0]   alu_z;

  // results
  logic [W-1:0] c_out;
  logic [2:0]   status;

  modport master (
    output data_in, vsel, writenum, write, readnum,
    output loada, loadb, shift, asel, bsel, sximm5,
    output loadc, loads, alu_out, alu_z,
    input  ain, bin, c_out, status
  );

  modport slave (
    input  data_in, vsel, writenum, write, readnum,
    input  loada, loadb, shift, asel, bsel, sximm5,
    input  loadc, loads, alu_out, alu_z,
    output ain, bin, c_out, status
  );
endinterface

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - register file, A/B operand regs, B shifter, C and status capture
module operand_stage #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  operand_stage_if.slave bus
);

  logic [W-1:0] regs [8];
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] c_reg;
  logic [2:0]   status_reg;

  logic [W-1:0] rd;
  logic [W-1:0] wb;
  logic [W-1:0] b_shifted;

  // Read is combinational off current contents, so a same-edge write is
  // never seen by loada/loadb until the following cycle.
  assign rd = regs[bus.readnum];
  assign wb = bus.vsel ? bus.data_in : c_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.write) begin
      regs[bus.writenum] <= wb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      status_reg <= '0;
    end else begin
      if (bus.loada) a_reg <= rd;
      if (bus.loadb) b_reg <= rd;
      if (bus.loadc) c_reg <= bus.alu_out;
      if (bus.loads) status_reg <= bus.alu_z;
    end
  end

  always_comb begin
    b_shifted = b_reg;
    unique case (bus.shift)
      2'b00: b_shifted = b_reg;
      2'b01: b_shifted = {b_reg[W-2:0], 1'b0};
      2'b10: b_shifted = {1'b0, b_reg[W-1:1]};
      2'b11: b_shifted = {b_reg[W-1], b_reg[W-1:1]};
      default: b_shifted = b_reg;
    endcase
  end

  assign bus.ain    = bus.asel ? '0 : a_reg;
  assign bus.bin    = bus.bsel ? bus.sximm5 : b_shifted;
  assign bus.c_out  = c_reg;
  assign bus.status = status_reg;

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - directed table plus randomized model check of operand_stage
module tb_operand_stage;
  localparam int W = 16;

  typedef struct {
    logic         rst;
    logic         write;
    logic [2:0]   writenum;
    logic         vsel;
    logic [W-1:0] data_in;
    logic [2:0]   readnum;
    logic         loada;
    logic         loadb;
    logic [1:0]   shift;
    logic         asel;
    logic         bsel;
    logic [W-1:0] sximm5;
    logic [W-1:0] alu_out;
    logic [2:0]   alu_z;
    logic         loadc;
    logic         loads;
    logic [W-1:0] e_ain;
    logic [W-1:0] e_bin;
    logic [W-1:0] e_c;
    logic [2:0]   e_s;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  operand_stage_if #(.W(W)) bus ();
  operand_stage #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  vec_t tbl[$];

  // reference state
  int unsigned m_r[8];
  int unsigned m_a, m_b, m_c, m_s;

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic push(input vec_t v, input int ea, input int eb, input int ec, input int es);
    v.e_ain = W'(ea);
    v.e_bin = W'(eb);
    v.e_c   = W'(ec);
    v.e_s   = 3'(es);
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset        = v.rst;
    bus.write    = v.write;
    bus.writenum = v.writenum;
    bus.vsel     = v.vsel;
    bus.data_in  = v.data_in;
    bus.readnum  = v.readnum;
    bus.loada    = v.loada;
    bus.loadb    = v.loadb;
    bus.shift    = v.shift;
    bus.asel     = v.asel;
    bus.bsel     = v.bsel;
    bus.sximm5   = v.sximm5;
    bus.alu_out  = v.alu_out;
    bus.alu_z    = v.alu_z;
    bus.loadc    = v.loadc;
    bus.loads    = v.loads;
  endtask

  task automatic check(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input int ea, input int eb, input int ec, input int es);
    check({tag, ".ain"},    idx, bus.ain,          W'(ea));
    check({tag, ".bin"},    idx, bus.bin,          W'(eb));
    check({tag, ".c_out"},  idx, bus.c_out,        W'(ec));
    check({tag, ".status"}, idx, W'(bus.status),   W'(es));
  endtask

  // B-path shift from the operation's arithmetic meaning
  function automatic int unsigned shf(input int unsigned b, input int unsigned op);
    int unsigned mask = (32'd1 << W) - 1;
    int unsigned msb  = 32'd1 << (W - 1);
    case (op)
      1: return (b * 2) & mask;
      2: return b / 2;
      3: return (b / 2) + ((b >= msb) ? msb : 0);
      default: return b;
    endcase
  endfunction

  task automatic model_step(input vec_t v);
    int unsigned nr[8];
    if (v.rst) begin
      foreach (m_r[i]) m_r[i] = 0;
      m_a = 0; m_b = 0; m_c = 0; m_s = 0;
    end else begin
      nr = m_r;
      if (v.write) nr[v.writenum] = v.vsel ? int'(v.data_in) : m_c;
      if (v.loada) m_a = m_r[v.readnum];
      if (v.loadb) m_b = m_r[v.readnum];
      if (v.loadc) m_c = v.alu_out;
      if (v.loads) m_s = v.alu_z;
      m_r = nr;
    end
  endtask

  initial begin
    vec_t v;

    v = blank(); v.rst = 1; drive(v);
    @(posedge clk); #1;
    check_all("reset", -1, 0, 0, 0, 0);

    v = blank(); v.write = 1; v.writenum = 3; v.vsel = 1; v.data_in = 'h1234; push(v, 0, 0, 0, 0);
    v = blank(); v.rst = 1; v.loads = 1; v.alu_z = 7; v.loadc = 1; v.alu_out = 'hFFFF;
    v.write = 1; v.writenum = 5; v.vsel = 1; v.data_in = 'h5555; push(v, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      v = blank(); v.readnum = 3'(i); v.loada = 1; v.loadb = 1; push(v, 0, 0, 0, 0);
    end
    // add path
    v = blank(); v.write = 1; v.writenum = 0; v.vsel = 1; v.data_in = 7; push(v, 0, 0, 0, 0);
    v = blank(); v.write = 1; v.writenum = 1; v.vsel = 1; v.data_in = 2; push(v, 0, 0, 0, 0);
    v = blank(); v.readnum = 0; v.loada = 1; push(v, 7, 0, 0, 0);
    v = blank(); v.readnum = 1; v.loadb = 1; push(v, 7, 2, 0, 0);
    v = blank(); v.alu_out = 9; v.loadc = 1; v.loads = 1; v.alu_z = 0; push(v, 7, 2, 9, 0);
    v = blank(); v.write = 1; v.writenum = 2; v.vsel = 0; push(v, 7, 2, 9, 0);
    v = blank(); v.readnum = 2; v.loada = 1; push(v, 9, 2, 9, 0);
    // writeback from C together with loadc stores the old C
    v = blank(); v.write = 1; v.writenum = 7; v.vsel = 0; v.loadc = 1; v.alu_out = 'h55; push(v, 9, 2, 'h55, 0);
    v = blank(); v.readnum = 7; v.loada = 1; push(v, 9, 2, 'h55, 0);
    // shifter
    v = blank(); v.write = 1; v.writenum = 5; v.vsel = 1; v.data_in = 'h8001; push(v, 9, 2, 'h55, 0);
    v = blank(); v.readnum = 5; v.loadb = 1; push(v, 9, 'h8001, 'h55, 0);
    v = blank(); v.shift = 1; push(v, 9, 'h0002, 'h55, 0);
    v = blank(); v.shift = 2; push(v, 9, 'h4000, 'h55, 0);
    v = blank(); v.shift = 3; push(v, 9, 'hC000, 'h55, 0);
    // operand select
    v = blank(); v.write = 1; v.writenum = 6; v.vsel = 1; v.data_in = 'h00FF; push(v, 9, 'h8001, 'h55, 0);
    v = blank(); v.readnum = 6; v.loada = 1; v.asel = 1; push(v, 0, 'h8001, 'h55, 0);
    v = blank(); push(v, 'hFF, 'h8001, 'h55, 0);
    v = blank(); v.bsel = 1; v.sximm5 = 'hFFF0; v.shift = 3; push(v, 'hFF, 'hFFF0, 'h55, 0);
    // same-cycle write/read collision
    v = blank(); v.write = 1; v.writenum = 4; v.vsel = 1; v.data_in = 5; push(v, 'hFF, 'h8001, 'h55, 0);
    v = blank(); v.write = 1; v.writenum = 4; v.vsel = 1; v.data_in = 'hAAAA;
    v.readnum = 4; v.loada = 1; push(v, 5, 'h8001, 'h55, 0);
    v = blank(); v.readnum = 4; v.loada = 1; push(v, 'hAAAA, 'h8001, 'h55, 0);
    // status capture
    v = blank(); v.alu_z = 6; push(v, 'hAAAA, 'h8001, 'h55, 0);
    v = blank(); v.alu_z = 6; v.loads = 1; push(v, 'hAAAA, 'h8001, 'h55, 6);
    v = blank(); v.rst = 1; v.alu_z = 5; v.loads = 1; push(v, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      check_all("table", i, tbl[i].e_ain, tbl[i].e_bin, tbl[i].e_c, tbl[i].e_s);
    end

    // randomized run against the reference model, starting from reset state
    foreach (m_r[i]) m_r[i] = 0;
    m_a = 0; m_b = 0; m_c = 0; m_s = 0;
    for (int n = 0; n < 600; n++) begin
      v = blank();
      v.rst      = ($urandom_range(0, 40) == 0);
      v.write    = 1'($urandom);
      v.writenum = 3'($urandom);
      v.vsel     = 1'($urandom);
      v.data_in  = W'($urandom);
      v.readnum  = 3'($urandom);
      v.loada    = 1'($urandom);
      v.loadb    = 1'($urandom);
      v.shift    = 2'($urandom);
      v.asel     = ($urandom_range(0, 3) == 0);
      v.bsel     = ($urandom_range(0, 3) == 0);
      v.sximm5   = W'($signed(5'($urandom)));
      v.alu_out  = W'($urandom);
      v.alu_z    = 3'($urandom);
      v.loadc    = 1'($urandom);
      v.loads    = 1'($urandom);
      drive(v);
      model_step(v);
      @(posedge clk); #1;
      check_all("rand", n, v.asel ? 0 : int'(m_a),
                v.bsel ? int'(v.sximm5) : int'(shf(m_b, v.shift)),
                int'(m_c), int'(m_s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/operand_stage.md
# operand_stage

Register/operand stage of the RISC datapath, directly upstream of the ALU. It holds the 8×16 register file, the A and B operand registers, the B-path shifter and the operand-select muxes that drive the ALU's `Ain`/`Bin`. It also captures the ALU result in register C and the ALU's 3-bit `{Z,V,N}` flags in the status register, and selects the writeback value into the register file. All state is controlled cycle by cycle by the CPU controller FSM.

## Interface
Parameters:
- `W`, 16, datapath width; fixed at 16 for the CPU, parameterised for the bench.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `data_in`  in  W  external writeback value (immediate / memory data).
- `vsel`  in  1  writeback source: 0 = C register, 1 = `data_in`.
- `writenum`  in  3  register-file write index.
- `write`  in  1  register-file write enable.
- `readnum`  in  3  register-file read index (combinational read).
- `loada`  in  1  capture read data into A.
- `loadb`  in  1  capture read data into B.
- `shift`  in  2  B-path shift op.
- `asel`  in  1  1 = force `ain` to 0.
- `bsel`  in  1  1 = `bin` takes `sximm5`.
- `sximm5`  in  W  sign-extended 5-bit immediate.
- `ain`  out  W  ALU A operand.
- `bin`  out  W  ALU B operand.
- `alu_out`  in  W  ALU result.
- `alu_z`  in  3  ALU flags `{zero, overflow, negative}`.
- `loadc`  in  1  capture `alu_out` into C.
- `loads`  in  1  capture `alu_z` into status.
- `c_out`  out  W  C register, the datapath result.
- `status`  out  3  status register `{Z,V,N}`.

## Operation
- Register file: R0–R7, W bits each. Read is combinational: `rd = R[readnum]`. On a clock edge with `write=1`, `R[writenum] <= wb`.
- Writeback value: `wb = vsel ? data_in : C`.
- A/B registers: `A <= rd` when `loada=1`; `B <= rd` when `loadb=1`. Both may load in the same cycle and receive the same value.
- Shifter, applied to B (combinational):
  - 00: pass through.
  - 01: shift left 1; LSB = 0.
  - 10: logical shift right 1; MSB = 0.
  - 11: arithmetic shift right 1; MSB = B[W-1].
- Operand muxes: `ain = asel ? 0 : A`; `bin = bsel ? sximm5 : shifted B`.
- C register: `C <= alu_out` when `loadc=1`. Status register: `status <= alu_z` when `loads=1`. All other registers hold their value.
- Read-before-write: if `write` and `loada`/`loadb` are active in the same cycle with `writenum == readnum`, A/B capture the old register value. The new value is readable from the next cycle.
- Writeback from C with `loadc` in the same cycle writes the old C value.

## Timing
- `reset=1` at an edge: R0–R7, A, B, C and status all become 0. Reset overrides every load and write asserted in the same cycle.
- Reset asserted mid-sequence (for example between `loada` and `loadc`) discards all partial state. There are no pending operations.
- Outputs after reset: `c_out = 0`, `status = 000`, `ain = 0`, `bin = 0` (or `sximm5` if `bsel=1`).
- Latencies:
  - Register write to readable: 1 cycle.
  - `loada`/`loadb` to `ain`/`bin`: visible after the edge.
  - ALU is combinational, so `loadc`/`loads` in the cycle after the operand loads captures the result. A full ADD sequence (load A, load B, load C/S, write back) takes 4 edges.
- `ain`, `bin`, `c_out` and `status` are glitch-free register or mux outputs. There are no combinational paths from `alu_out`/`alu_z` to any output.

## Test plan
- Reset and reads:
  - Write R3 = 0x1234 and assert reset.
  - Read each of R0–R7 through A: all = 0.
  - `c_out = 0`, `status = 000`.
- Add path:
  - Write R0 = 7 and R1 = 2; load A from R0 and B from R1, `shift = 00`.
  - ALU add returns 9; `loadc`, then writeback to R2 with `vsel = 0`.
  - R2 = 9; status `{0,0,0}`.
- Shifter:
  - Load B = 0x8001.
  - `shift` 01 → `bin = 0x0002`; 10 → `0x4000`; 11 → `0xC000`.
- Operand select:
  - A = 0x00FF, `asel = 1` → `ain = 0`.
  - `bsel = 1`, `sximm5 = 0xFFF0` → `bin = 0xFFF0` regardless of B.
- Same-cycle collision:
  - R4 = 5; in one cycle write R4 = 0xAAAA (`vsel = 1`) with `loada`, `readnum = 4`.
  - A = 5; next-cycle load gives A = 0xAAAA.
- Status capture:
  - Drive `alu_z = 110` with `loads = 0` → status unchanged.
  - Then `loads = 1` → `status = 110`.
  - Assert reset in the same cycle as `loads` → `status = 000`.
